// File: rtl/hour_counter_bcd.sv
// hour_counter_bcd -- BCD hour-of-day counter (00..23) with a host load port.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   c_in         one-cycle hour-advance pulse (carry from the minutes-tens stage)
//   set_valid    host load request; held by the host until accepted
//   set_tens     requested hour, BCD tens (sampled on handshake)
//   set_units    requested hour, BCD units (sampled on handshake)
//   set_ready    block can accept a load (RUN state, not in reset)
//   set_err      one-cycle pulse: the staged request was illegal and discarded
//   tens, units  registered BCD hour
//   carry_day    one-cycle pulse when an advance wraps 23 -> 00
//
// Optional feature (macro HOUR_ALARM_EN):
//   alarm_tens, alarm_units  alarm hour (BCD)
//   alarm_hit                one-cycle pulse when a c_in advance lands on the alarm hour
//
// A load is handshaken in RUN into a staging register, validated during the
// single CHECK cycle, and applied at the end of CHECK. c_in is honoured in
// every cycle, so an advance is applied on top of whichever value wins.

module hour_counter_bcd (
  input  logic       clk,
  input  logic       reset,
  input  logic       c_in,
  input  logic       set_valid,
  input  logic [1:0] set_tens,
  input  logic [3:0] set_units,
`ifdef HOUR_ALARM_EN
  input  logic [1:0] alarm_tens,
  input  logic [3:0] alarm_units,
  output logic       alarm_hit,
`endif
  output logic       set_ready,
  output logic       set_err,
  output logic [1:0] tens,
  output logic [3:0] units,
  output logic       carry_day
);

  typedef enum logic {RUN, CHECK} state_t;

  state_t     state, state_n;
  logic [1:0] stage_tens, stage_tens_n;
  logic [3:0] stage_units, stage_units_n;
  logic [1:0] tens_n, base_tens;
  logic [3:0] units_n, base_units;
  logic       carry_n, err_n, legal;
`ifdef HOUR_ALARM_EN
  logic       alarm_n;
`endif

  // Returns {wrap, tens, units} of the hour following t:u.
  function automatic logic [6:0] advance(input logic [1:0] t, input logic [3:0] u);
    if (t == 2'd2 && u == 4'd3)
      advance = {1'b1, 2'd0, 4'd0};
    else if (u == 4'd9)
      advance = {1'b0, t + 2'd1, 4'd0};
    else
      advance = {1'b0, t, u + 4'd1};
  endfunction

  assign set_ready = (state == RUN) && !reset;

  assign legal = (stage_tens <= 2'd2) && (stage_units <= 4'd9) &&
                 ((stage_tens < 2'd2) || (stage_units <= 4'd3));

  always_comb begin
    state_n       = state;
    stage_tens_n  = stage_tens;
    stage_units_n = stage_units;
    base_tens     = tens;
    base_units    = units;
    tens_n        = tens;
    units_n       = units;
    carry_n       = 1'b0;
    err_n         = 1'b0;
`ifdef HOUR_ALARM_EN
    alarm_n       = 1'b0;
`endif

    unique case (state)
      RUN: begin
        if (set_valid && set_ready) begin
          stage_tens_n  = set_tens;
          stage_units_n = set_units;
          state_n       = CHECK;
        end
      end
      CHECK: begin
        state_n = RUN;
        if (legal) begin
          base_tens  = stage_tens;
          base_units = stage_units;
        end else begin
          err_n = 1'b1;
        end
      end
    endcase

    // The advance is applied to the winning base value, so a load and a
    // c_in in the same CHECK cycle yield (loaded value + 1).
    if (c_in) begin
      {carry_n, tens_n, units_n} = advance(base_tens, base_units);
`ifdef HOUR_ALARM_EN
      alarm_n = (tens_n == alarm_tens) && (units_n == alarm_units);
`endif
    end else begin
      tens_n  = base_tens;
      units_n = base_units;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      stage_tens  <= '0;
      stage_units <= '0;
      tens        <= '0;
      units       <= '0;
      carry_day   <= 1'b0;
      set_err     <= 1'b0;
`ifdef HOUR_ALARM_EN
      alarm_hit   <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      stage_tens  <= stage_tens_n;
      stage_units <= stage_units_n;
      tens        <= tens_n;
      units       <= units_n;
      carry_day   <= carry_n;
      set_err     <= err_n;
`ifdef HOUR_ALARM_EN
      alarm_hit   <= alarm_n;
`endif
    end
  end

endmodule

// File: tb/tb_hour_counter_bcd.sv
// Self-checking bench for hour_counter_bcd. The driver applies one cycle of
// inputs per call and queues the outputs expected after that clock edge; the
// monitor pops and compares one entry after every rising edge.
`timescale 1ns/1ps

module tb_hour_counter_bcd;

  logic       clk = 1'b0;
  logic       reset, c_in, set_valid;
  logic [1:0] set_tens;
  logic [3:0] set_units;
  logic       set_ready, set_err, carry_day;
  logic [1:0] tens;
  logic [3:0] units;
`ifdef HOUR_ALARM_EN
  logic [1:0] alarm_tens = 2'd0;
  logic [3:0] alarm_units = 4'd7;
  logic       alarm_hit;
`endif

  always #5 clk = ~clk;

  hour_counter_bcd dut (
    .clk(clk), .reset(reset), .c_in(c_in), .set_valid(set_valid),
    .set_tens(set_tens), .set_units(set_units),
`ifdef HOUR_ALARM_EN
    .alarm_tens(alarm_tens), .alarm_units(alarm_units), .alarm_hit(alarm_hit),
`endif
    .set_ready(set_ready), .set_err(set_err), .tens(tens), .units(units),
    .carry_day(carry_day)
  );

  typedef struct {
    int         tag;
    logic [1:0] t;
    logic [3:0] u;
    logic       carry, err, ready, alarm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tagn   = 0;

  task automatic chk(input string name, input int tag, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: actual %0d required %0d", name, tag, act, req);
    end
  endtask

  // Monitor: every rising edge produces one set of outputs to compare.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("tens",      e.tag, int'(tens),      int'(e.t));
        chk("units",     e.tag, int'(units),     int'(e.u));
        chk("carry_day", e.tag, int'(carry_day), int'(e.carry));
        chk("set_err",   e.tag, int'(set_err),   int'(e.err));
        chk("set_ready", e.tag, int'(set_ready), int'(e.ready));
`ifdef HOUR_ALARM_EN
        chk("alarm_hit", e.tag, int'(alarm_hit), int'(e.alarm));
`endif
      end
    end
  end

  // Driver: inputs for one cycle plus the outputs expected after its edge.
  task automatic step(input logic r, input logic ci, input logic sv,
                      input logic [1:0] st, input logic [3:0] su,
                      input logic [1:0] et, input logic [3:0] eu,
                      input logic ec, input logic ee, input logic er,
                      input logic ea);
    exp_t e;
    @(negedge clk);
    reset = r; c_in = ci; set_valid = sv; set_tens = st; set_units = su;
    tagn++;
    e.tag = tagn; e.t = et; e.u = eu; e.carry = ec; e.err = ee;
    e.ready = er; e.alarm = ea;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; c_in = 1'b0; set_valid = 1'b0; set_tens = '0; set_units = '0;

    // reset
    step(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);

    // 23 advances: 01..23, no carry_day; alarm (07) hit on the 7th
    for (int i = 1; i <= 23; i++)
      step(0, 1, 0, 0, 0,  2'(i / 10), 4'(i % 10), 0, 0, 1, (i == 7));
    // 24th: wrap to 00 with carry_day for one cycle
    step(0, 1, 0, 0, 0,  0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);

    // load 19, no c_in: ready drops one cycle, count 19 after two edges
    step(0, 0, 1, 1, 9,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  1, 9, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0,  1, 9, 0, 0, 1, 0);

    // load 24: illegal, count unchanged, single set_err pulse
    step(0, 0, 1, 2, 4,  1, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  1, 9, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0,  1, 9, 0, 0, 1, 0);
    // load 3A: illegal
    step(0, 0, 1, 3, 10, 1, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  1, 9, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0,  1, 9, 0, 0, 1, 0);
    // illegal load with c_in in CHECK: current count still advances
    step(0, 0, 1, 2, 5,  1, 9, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0,  2, 0, 0, 1, 1, 0);

    // load 05, then handshake 23 with c_in (->06), c_in in CHECK (->00, carry)
    step(0, 0, 1, 0, 5,  2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 5, 0, 0, 1, 0);
    step(0, 1, 1, 2, 3,  0, 6, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0,  0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);

    // load 09 with c_in in CHECK -> 10 (units wrap on a loaded value)
    step(0, 0, 1, 0, 9,  0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0);

    // reset in CHECK while loading 12: 12 never appears
    step(0, 0, 1, 1, 2,  1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);

    // reset has priority over c_in and a handshake
    step(0, 1, 0, 0, 0,  0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0,  0, 2, 0, 0, 1, 0);
    step(1, 1, 1, 1, 5,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);

    // alarm 07: load 06 then c_in -> hit; loading 07 alone -> no hit
    step(0, 0, 1, 0, 6,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 6, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0,  0, 7, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0,  0, 7, 0, 0, 1, 0);
    step(0, 0, 1, 0, 7,  0, 7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 7, 0, 0, 1, 0);
    step(0, 0, 1, 0, 5,  0, 7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 5, 0, 0, 1, 0);
    step(0, 0, 1, 0, 7,  0, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 7, 0, 0, 1, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: actual %0d entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hour_counter_bcd.md
HOUR_COUNTER_BCD -- requirements
Module: hour_counter_bcd

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 c_in  input  1  one-cycle hour-advance pulse from upstream minutes-tens stage carry.
REQ-005 set_valid  input  1  host requests hour load.
REQ-006 set_tens  input  2  BCD tens of requested hour; sampled on handshake.
REQ-007 set_units  input  4  BCD units of requested hour; sampled on handshake.
REQ-008 set_ready  output  1  block can accept a load request.
REQ-009 set_err  output  1  one-cycle pulse: staged request was illegal and discarded.
REQ-010 tens  output  2  registered BCD hour tens, 0..2.
REQ-011 units  output  4  registered BCD hour units, 0..9.
REQ-012 carry_day  output  1  one-cycle pulse on wrap 23 -> 00.

Function
REQ-013 Count range: 00..23 BCD; units wrap 9 -> 0 with tens +1; 23 -> 00 wraps and asserts carry_day in the same cycle as the update.
REQ-014 Two-state FSM: RUN, CHECK.
REQ-015 set_ready = 1 only in RUN and not in reset.
REQ-016 RUN: c_in=1 advances the count by one on the next edge; c_in=0 holds.
REQ-017 RUN with set_valid & set_ready: capture set_tens/set_units into staging register, go to CHECK; c_in in the same cycle still advances the current count.
REQ-018 CHECK (exactly one cycle, then RUN): staged value is legal iff tens<=2, units<=9, and (tens<2 or units<=3).
REQ-019 CHECK, legal: next count = staged value, advanced by one if c_in=1 in that cycle.
REQ-020 CHECK, illegal: count is kept (advanced by one if c_in=1); set_err pulses on the next edge.
REQ-021 carry_day asserts whenever any advance (RUN or CHECK) takes 23 -> 00, including a loaded 23 plus c_in.
REQ-022 c_in is never lost or doubled: at most one advance per cycle, exactly one per c_in pulse.
REQ-023 set_valid is ignored in CHECK; the host holds it until the handshake completes.
REQ-024 Outputs are registered; count latency from c_in is 1 cycle; load latency from handshake is 2 cycles.

Reset
REQ-025 reset=1 at a clk edge: tens=0, units=0, FSM=RUN, staging=00, carry_day=0, set_err=0.
REQ-026 set_ready=0 while reset=1.
REQ-027 Reset asserted in CHECK aborts the load; the staged value is never applied.
REQ-028 Reset has priority over c_in and the handshake.

Configuration
REQ-029 Macro HOUR_ALARM_EN defined: adds inputs alarm_tens[1:0] and alarm_units[3:0], and output alarm_hit (reset 0).
REQ-030 With HOUR_ALARM_EN, alarm_hit pulses one cycle when a c_in advance makes the count equal the alarm value; loads alone never trigger it.
REQ-031 Without HOUR_ALARM_EN, these ports and logic are absent; all other behaviour is identical.

Verification
REQ-032 Reset, then 23 c_in pulses -> count 23, carry_day never high; 24th pulse -> 00 with carry_day=1 for one cycle.
REQ-033 Load 19 with no c_in -> set_ready drops 1 cycle, count=19 two cycles after handshake, set_err=0.
REQ-034 Load 24, then separately 3A -> set_err pulses once each, count unchanged.
REQ-035 Count 05, c_in in the handshake cycle, load 23, c_in in CHECK -> count goes 06, then 00 with carry_day=1.
REQ-036 Reset asserted in CHECK while loading 12 -> count 00, set_ready=1 after reset deasserts, 12 never appears.
REQ-037 With HOUR_ALARM_EN, alarm=07, count 06 plus c_in -> alarm_hit=1 for one cycle; loading 07 -> alarm_hit=0.
